// File: rtl/mandelbrot_batch_scheduler.sv
// mandelbrot_batch_scheduler: issues pixel batches to NUM_LANES point-generator lanes and streams results in raster order
//   CLK/RST                    clock, synchronous active-high reset
//   start_render/abort/x_size/y_size   frame control
//   lane_start/lane_x/lane_y   per-lane start pulse and coordinates
//   lane_done/lane_iter        per-lane completion pulse and iteration count
//   out_valid/out_ready/out_data/out_pixel/out_last   result stream
//   busy/frame_done            frame status
module mandelbrot_batch_scheduler #(
    parameter int NUM_LANES = 16,
    parameter int ITER_W    = 32,
    parameter int COORD_W   = 12,
    parameter int PIX_W     = 24
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           start_render,
    input  logic                           abort,
    input  logic [COORD_W-1:0]             x_size,
    input  logic [COORD_W-1:0]             y_size,
    output logic [NUM_LANES-1:0]           lane_start,
    output logic [NUM_LANES*COORD_W-1:0]   lane_x,
    output logic [NUM_LANES*COORD_W-1:0]   lane_y,
    input  logic [NUM_LANES-1:0]           lane_done,
    input  logic [NUM_LANES*ITER_W-1:0]    lane_iter,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ITER_W-1:0]              out_data,
    output logic [PIX_W-1:0]               out_pixel,
    output logic                           out_last,
    output logic                           busy,
    output logic                           frame_done
);
    localparam int SW = $clog2(NUM_LANES);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;
    localparam logic [COORD_W-1:0] CONE = 1;
    localparam logic [PIX_W-1:0] PONE = 1;

    logic [1:0] st;
    logic [COORD_W-1:0] xs, cx, cy, nx, ny;
    logic [COORD_W-1:0] gx [NUM_LANES];
    logic [COORD_W-1:0] gy [NUM_LANES];
    logic [PIX_W-1:0] total, base, rem, area;
    logic [PIX_W:0] next_base;
    logic [NUM_LANES-1:0] started, cap, mask;
    logic tgt, rd;
    logic [SW-1:0] rs;
    logic [1:0] full;
    logic [PIX_W-1:0] bank_base [2];
    logic [SW-1:0] bank_last [2];
    logic [ITER_W-1:0] mem [2][NUM_LANES];
    logic accept, issue, done_all, xfer;

    assign area      = PIX_W'({{COORD_W{1'b0}}, x_size} * {{COORD_W{1'b0}}, y_size});
    assign accept    = start_render && !abort && st == IDLE && !busy;
    assign issue     = st == ISSUE && !full[tgt];
    assign done_all  = st == WAIT && cap == started;
    assign next_base = {1'b0, base} + (PIX_W+1)'(NUM_LANES);
    assign rem       = total - base;
    assign xfer      = out_valid && out_ready;
    assign out_valid = full[rd];
    assign out_data  = out_valid ? mem[rd][rs] : '0;
    assign out_pixel = out_valid ? bank_base[rd] + PIX_W'(rs) : '0;
    assign out_last  = out_valid && out_pixel == total - PONE;

    // walk the raster from the batch's first pixel with a wrapping x counter
    always_comb begin
        nx = cx;
        ny = cy;
        mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            gx[i] = nx;
            gy[i] = ny;
            mask[i] = ({1'b0, base} + (PIX_W+1)'(i)) < {1'b0, total};
            ny = (nx == xs - CONE) ? ny + CONE : ny;
            nx = (nx == xs - CONE) ? '0 : nx + CONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st <= IDLE;
            full <= '0;
            busy <= 1'b0;
            frame_done <= 1'b0;
            lane_start <= '0;
            lane_x <= '0;
            lane_y <= '0;
            started <= '0;
            cap <= '0;
            tgt <= 1'b0;
            rd <= 1'b0;
            rs <= '0;
            xs <= '0;
            total <= '0;
            base <= '0;
            cx <= '0;
            cy <= '0;
            bank_base[0] <= '0;
            bank_base[1] <= '0;
            bank_last[0] <= '0;
            bank_last[1] <= '0;
        end else if (abort) begin
            st <= IDLE;
            full <= '0;
            busy <= 1'b0;
            frame_done <= 1'b0;
            lane_start <= '0;
            started <= '0;
            cap <= '0;
            rd <= 1'b0;
            rs <= '0;
        end else begin
            frame_done <= 1'b0;
            lane_start <= '0;
            if (accept) begin
                // an empty frame completes immediately without leaving IDLE
                frame_done <= area == '0;
                if (area != '0) begin
                    busy <= 1'b1;
                    st <= ISSUE;
                    xs <= x_size;
                    total <= area;
                    base <= '0;
                    cx <= '0;
                    cy <= '0;
                    tgt <= 1'b0;
                    rd <= 1'b0;
                    rs <= '0;
                end
            end
            if (issue) begin
                lane_start <= mask;
                started <= mask;
                cap <= '0;
                cx <= nx;
                cy <= ny;
                st <= WAIT;
                for (int i = 0; i < NUM_LANES; i++) begin
                    lane_x[i*COORD_W +: COORD_W] <= gx[i];
                    lane_y[i*COORD_W +: COORD_W] <= gy[i];
                end
            end
            if (st == WAIT)
                cap <= cap | (lane_done & started);
            if (done_all) begin
                full[tgt] <= 1'b1;
                bank_base[tgt] <= base;
                bank_last[tgt] <= rem >= PIX_W'(NUM_LANES) ? SW'(NUM_LANES - 1) : SW'(rem - PONE);
                base <= next_base[PIX_W-1:0];
                tgt <= ~tgt;
                st <= next_base >= {1'b0, total} ? IDLE : ISSUE;
            end
            if (xfer) begin
                if (rs == bank_last[rd]) begin
                    full[rd] <= 1'b0;
                    rd <= ~rd;
                    rs <= '0;
                    if (out_last) begin
                        busy <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end else begin
                    rs <= rs + SW'(1);
                end
            end
        end
    end

    // duplicate or unsolicited completions are dropped by the started/captured masks
    always_ff @(posedge CLK) begin
        if (!RST && !abort && st == WAIT)
            for (int i = 0; i < NUM_LANES; i++)
                if (lane_done[i] && started[i] && !cap[i])
                    mem[tgt][i] <= lane_iter[i*ITER_W +: ITER_W];
    end
endmodule

// File: tb/tb_mandelbrot_batch_scheduler.sv
// tb_mandelbrot_batch_scheduler: directed scoreboard bench for the batch scheduler
module tb_mandelbrot_batch_scheduler;
    localparam int N = 4, IW = 16, CW = 8, PW = 16;

    typedef struct packed {
        logic [PW-1:0] pix;
        logic [IW-1:0] dat;
        logic          last;
    } exp_t;

    logic CLK = 1'b0, RST = 1'b1, start_render = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic [CW-1:0] x_size = '0, y_size = '0;
    logic [N-1:0] lane_start, lane_done = '0;
    logic [N*CW-1:0] lane_x, lane_y;
    logic [N*IW-1:0] lane_iter = '0;
    logic out_valid, out_last, busy, frame_done;
    logic [IW-1:0] out_data;
    logic [PW-1:0] out_pixel;

    mandelbrot_batch_scheduler #(.NUM_LANES(N), .ITER_W(IW), .COORD_W(CW), .PIX_W(PW)) dut (
        .CLK(CLK), .RST(RST), .start_render(start_render), .abort(abort),
        .x_size(x_size), .y_size(y_size), .lane_start(lane_start), .lane_x(lane_x),
        .lane_y(lane_y), .lane_done(lane_done), .lane_iter(lane_iter),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pixel(out_pixel), .out_last(out_last), .busy(busy), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    exp_t sbq[$];
    int total = 0, bad = 0;
    int cyc = 0, xfers = 0, issues = 0, fd_cnt = 0, last_cyc = 0;
    int salt = 0, dly = 3, fd_base = 0, iss_base = 0;
    bit rev = 0, last_seen = 0, busy_seen = 0, valid_seen = 0;
    logic [N-1:0] last_ls = '0;
    logic [CW-1:0] l0x = '0, l0y = '0;
    int cnt [N] = '{default: 0};
    int px [N] = '{default: 0};
    int py [N] = '{default: 0};

    function automatic logic [IW-1:0] iter_of(input int x, input int y, input int s);
        return IW'(((s % 16) << 12) | ((y % 64) << 6) | (x % 64));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    // point-generator lanes: answer a fixed or lane-reversed number of cycles after their start pulse
    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            lane_done[i] = 1'b0;
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    lane_done[i] = 1'b1;
                    lane_iter[i*IW +: IW] = iter_of(px[i], py[i], salt);
                end
            end
            if (lane_start[i]) begin
                cnt[i] = rev ? 2 + (N - 1 - i) * 2 : dly;
                px[i] = int'(lane_x[i*CW +: CW]);
                py[i] = int'(lane_y[i*CW +: CW]);
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (busy) busy_seen = 1;
            if (out_valid) valid_seen = 1;
            if (lane_start != '0) begin
                issues++;
                last_ls = lane_start;
                l0x = lane_x[CW-1:0];
                l0y = lane_y[CW-1:0];
            end
            if (frame_done) begin
                fd_cnt++;
                chk("busy_at_done", busy, 0);
                if (last_seen) chk("done_lag", cyc - last_cyc, 1);
                last_seen = 0;
            end
            if (out_valid && out_ready) begin
                xfers++;
                if (out_last) begin
                    last_seen = 1;
                    last_cyc = cyc;
                end
                if (sbq.size() == 0) chk("sb_unexpected", {out_pixel, out_data, out_last}, 0);
                else chk("out", {out_pixel, out_data, out_last}, sbq.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic run(input int x, input int y, input int s);
        salt = s;
        for (int p = 0; p < x * y; p++)
            sbq.push_back('{pix: PW'(p), dat: iter_of(p % x, p / x, s), last: p == x * y - 1});
        fd_base = fd_cnt;
        iss_base = issues;
        x_size = CW'(x);
        y_size = CW'(y);
        start_render = 1'b1;
        tick(1);
        start_render = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (fd_cnt == fd_base && n < 500) begin
            tick(1);
            n++;
        end
        chk({tag, "_timeout"}, n < 500, 1);
        chk({tag, "_sb_left"}, sbq.size(), 0);
        tick(2);
    endtask

    task automatic wait_xfers(input int k);
        int n = 0;
        int t0 = xfers;
        while (xfers < t0 + k && n < 300) begin
            tick(1);
            n++;
        end
        chk("xfer_timeout", n < 300, 1);
    endtask

    initial begin
        int f0, i0, n;
        logic [PW-1:0] hp;
        logic [IW-1:0] hd;
        tick(3);
        chk("reset_outs", {lane_start, lane_x, lane_y, out_valid, out_data, out_pixel, out_last, busy, frame_done}, 0);
        RST = 1'b0;
        tick(2);

        run(4, 2, 1);
        wait_done("f4x2");
        chk("f4x2_issues", issues - iss_base, 2);

        rev = 1;
        run(3, 3, 2);
        wait_done("f3x3");
        chk("f3x3_issues", issues - iss_base, 3);
        chk("f3x3_last_ls", last_ls, 4'b0001);
        chk("f3x3_last_xy", {l0x, l0y}, {8'd2, 8'd2});
        rev = 0;

        run(4, 4, 3);
        wait_xfers(2);
        out_ready = 1'b0;
        hp = out_pixel;
        hd = out_data;
        tick(10);
        chk("stall_pixel", out_pixel, hp);
        chk("stall_data", out_data, hd);
        chk("stall_valid", out_valid, 1);
        chk("stall_issues", issues - iss_base, 2);
        chk("stall_ls", lane_start, 0);
        out_ready = 1'b1;
        wait_done("f4x4");
        chk("f4x4_issues", issues - iss_base, 4);

        busy_seen = 0;
        f0 = fd_cnt;
        i0 = issues;
        x_size = 8'd0;
        y_size = 8'd5;
        start_render = 1'b1;
        tick(1);
        start_render = 1'b0;
        chk("zero_fd", {frame_done, busy}, 2'b10);
        tick(3);
        chk("zero_fd_cnt", fd_cnt - f0, 1);
        chk("zero_issues", issues - i0, 0);
        chk("zero_busy", busy_seen, 0);

        dly = 8;
        iss_base = issues;
        x_size = 8'd4;
        y_size = 8'd2;
        start_render = 1'b1;
        tick(1);
        start_render = 1'b0;
        n = 0;
        while (issues == iss_base && n < 50) begin
            tick(1);
            n++;
        end
        chk("abort_issue_timeout", n < 50, 1);
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_outs", {out_valid, busy, frame_done, lane_start}, 0);
        f0 = fd_cnt;
        valid_seen = 0;
        tick(15);
        chk("abort_no_valid", valid_seen, 0);
        chk("abort_no_fd", fd_cnt - f0, 0);
        chk("abort_busy", busy, 0);
        dly = 3;

        run(2, 2, 4);
        wait_done("f2x2");

        busy_seen = 0;
        i0 = issues;
        start_render = 1'b1;
        abort = 1'b1;
        tick(1);
        start_render = 1'b0;
        abort = 1'b0;
        tick(5);
        chk("start_abort_busy", busy_seen, 0);
        chk("start_abort_issues", issues - i0, 0);

        run(4, 4, 5);
        wait_xfers(3);
        RST = 1'b1;
        tick(1);
        chk("rst_outs", {lane_start, lane_x, lane_y, out_valid, out_data, out_pixel, out_last, busy, frame_done}, 0);
        sbq.delete();
        RST = 1'b0;
        i0 = issues;
        tick(20);
        chk("rst_no_issue", issues - i0, 0);

        run(3, 2, 6);
        wait_done("f3x2");
        chk("f3x2_issues", issues - iss_base, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
